// File: rtl/frog_referee.sv
// frog_referee: game-logic stage behind the frog position FSM.
// Scrolls an LFSR-fed hazard lane, detects collisions and wins, and keeps
// lives and score. It also pulses frog_reset to send the frog back to square 0.
// Optional build macro FROG_SPEEDUP_EN: every win shortens the scroll period,
// down to a floor of a quarter of TICK_DIV.
module frog_referee #(
  parameter int          WIDTH    = 19,
  parameter int          TICK_DIV = 25000000,
  parameter int          HOLD     = 50000000,
  parameter int          LIVES    = 3,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] frog,
  output logic [WIDTH-1:0] hazard,
  output logic             frog_reset,
  output logic [1:0]       lives,
  output logic [7:0]       score,
  output logic [1:0]       game_state,
  output logic             game_over
);

  typedef enum logic [1:0] {PLAY = 2'd0, HIT = 2'd1, WIN = 2'd2, OVER = 2'd3} state_t;

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SAFE_MASK = ~(ONE | (ONE << (WIDTH - 1)));

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] lane_q, lane_d;
  logic [WIDTH-1:0] hazard_q, hazard_d;
  logic [1:0]       lives_q, lives_d;
  logic [7:0]       score_q, score_d;
  logic             frog_reset_q, frog_reset_d;
  logic             game_over_q, game_over_d;
  logic             tick;
  logic [CW-1:0]    term;

`ifdef FROG_SPEEDUP_EN
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] period_dec;
  assign term       = period_q - CW'(1);
  assign period_dec = period_q - CW'(TICK_DIV / 8);
`else
  assign term = CW'(TICK_DIV - 1);
`endif

  // Galois right-shift step for x^16+x^14+x^13+x^11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Score increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The lane keeps the raw scroll so a new hazard entering at the goal end
  // survives; the visible hazard masks both safe squares every cycle.
  // Next-state, scroll and scoring logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    hold_d       = hold_q;
    lfsr_d       = lfsr_q;
    lane_d       = lane_q;
    lives_d      = lives_q;
    score_d      = score_q;
    frog_reset_d = 1'b0;
    game_over_d  = 1'b0;
    tick         = 1'b0;
`ifdef FROG_SPEEDUP_EN
    period_d     = period_q;
`endif
    case (state_q)
      PLAY: begin
        tick  = (cnt_q == term);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          lane_d = {lfsr_q[0] & lfsr_q[1], lane_q[WIDTH-1:1]};
          lfsr_d = lfsr_step(lfsr_q);
        end
        // Collision outranks reaching the goal.
        if (|(frog & hazard_q)) begin
          state_d      = HIT;
          lives_d      = lives_q - 2'd1;
          lane_d       = '0;
          cnt_d        = '0;
          hold_d       = HW'(HOLD - 1);
          frog_reset_d = 1'b1;
        end else if (frog[WIDTH-1]) begin
          state_d      = WIN;
          score_d      = sat_inc(score_q);
          lane_d       = '0;
          cnt_d        = '0;
          hold_d       = HW'(HOLD - 1);
          frog_reset_d = 1'b1;
`ifdef FROG_SPEEDUP_EN
          period_d = (period_dec < CW'(TICK_DIV / 4)) ? CW'(TICK_DIV / 4) : period_dec;
`endif
        end
      end
      HIT: begin
        if (hold_q == '0) begin
          if (lives_q == 2'd0) begin
            state_d      = OVER;
            frog_reset_d = 1'b1;
            game_over_d  = 1'b1;
          end else begin
            state_d = PLAY;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      WIN: begin
        if (hold_q == '0) state_d = PLAY;
        else              hold_d  = hold_q - HW'(1);
      end
      default: begin
        frog_reset_d = 1'b1;
        game_over_d  = 1'b1;
      end
    endcase
    hazard_d = lane_d & SAFE_MASK;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PLAY;
      cnt_q        <= '0;
      hold_q       <= '0;
      lfsr_q       <= SEED;
      lane_q       <= '0;
      hazard_q     <= '0;
      lives_q      <= 2'(LIVES);
      score_q      <= '0;
      frog_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
`ifdef FROG_SPEEDUP_EN
      period_q     <= CW'(TICK_DIV);
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      lfsr_q       <= lfsr_d;
      lane_q       <= lane_d;
      hazard_q     <= hazard_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      frog_reset_q <= frog_reset_d;
      game_over_q  <= game_over_d;
`ifdef FROG_SPEEDUP_EN
      period_q     <= period_d;
`endif
    end
  end

  assign hazard     = hazard_q;
  assign frog_reset = frog_reset_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign game_state = state_q;
  assign game_over  = game_over_q;

endmodule

// File: doc/frog_referee.md
Name: frog_referee

Overview:
- Game-logic stage directly downstream of the frog position FSM.
- Consumes its 19-bit one-hot `frog` vector.
- Generates a scrolling hazard lane and detects collisions and wins.
- Tracks lives and score, and drives the position FSM's `reset` input via `frog_reset` to send the frog back to square 0.

Parameters:
- WIDTH, 19: board length; must match the frog vector width.
- TICK_DIV, 25000000: clock cycles per hazard scroll step.
- HOLD, 50000000: cycles spent in HIT/WIN before play resumes.
- LIVES, 3: starting lives, 1..3.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; 0 resets the block immediately.
- frog  in  WIDTH  one-hot frog position; bit 0 is start, bit WIDTH-1 is goal.
- hazard  out  WIDTH  current hazard lane; 1 means occupied.
- frog_reset  out  1  to the position FSM's reset input, active high.
- lives  out  2  remaining lives.
- score  out  8  completed crossings, saturating.
- game_state  out  2  PLAY=0, HIT=1, WIN=2, OVER=3.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset values:
  - game_state=PLAY, lives=LIVES, score=0, hazard=0.
  - frog_reset=0, game_over=0.
  - tick counter=0, hold counter=0, lfsr=SEED.
- All outputs are registered.
- Tick counter:
  - Counts 0..TICK_DIV-1 in PLAY only; it is cleared in every other state.
  - `tick` is a 1-cycle pulse when the count equals TICK_DIV-1; the count then wraps to 0.
- LFSR:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11.
  - Advances only on `tick`.
  - new_bit = lfsr[0] & lfsr[1] (25% density).
- Hazard scroll:
  - On `tick`, hazard <= {new_bit, hazard[WIDTH-1:1]}; hazards move toward start.
  - Bits 0 and WIDTH-1 are forced to 0 every cycle (safe squares).
- Evaluation in PLAY, on each clock edge, using the registered hazard and the sampled frog:
  - If |(frog & hazard): go to HIT. Collision has priority over win.
  - Else if frog[WIDTH-1]: go to WIN.
  - frog=0 or a non-one-hot frog vector is treated bitwise; no special case.
- Entry to HIT:
  - lives <= lives-1.
  - hazard <= 0.
  - frog_reset=1 for exactly that one cycle.
  - Hold counter loads HOLD-1.
- HIT hold:
  - Decrement the hold counter each cycle.
  - At 0: if lives==0 go to OVER, else go to PLAY.
- Entry to WIN:
  - score <= score+1, saturating at 255.
  - hazard <= 0.
  - frog_reset=1 for one cycle.
  - Hold counter loads HOLD-1; at 0 go to PLAY.
- While in HIT/WIN, frog is ignored and lives/score are not changed again.
- OVER:
  - Terminal state; exit only via rst.
  - game_over=1 and frog_reset held at 1.
  - hazard frozen; tick counter stopped; frog ignored.
- Latency: a collision or win is reflected in game_state and frog_reset one clock after the overlapping frog/hazard values are sampled.
- A hazard scroll and a frog move in the same cycle are evaluated on the next edge against the new values.
- Reset mid-operation: outputs go to their reset values immediately, independent of clk.

Optional Feature:
- Macro: FROG_SPEEDUP_EN.
- Defined:
  - A period register, reset to TICK_DIV, replaces TICK_DIV as the tick terminal count.
  - On each WIN entry: period <= max(period - TICK_DIV/8, TICK_DIV/4).
  - The tick counter is cleared when the period changes.
- Undefined: period is fixed at TICK_DIV; no extra registers.

Test Plan:
Run with TICK_DIV=4, HOLD=3, LIVES=3, SEED=16'hACE1.
- Reset: pulse rst=0 asynchronously mid-cycle -> immediately hazard=0, lives=3, score=0, game_state=0, frog_reset=0, game_over=0.
- Scroll: frog=19'h00001 held for 40 cycles -> hazard updates only every 4th cycle and matches the bench LFSR model; hazard[0] and hazard[18] are always 0; no state change.
- Collision: drive frog onto a set hazard bit -> next edge game_state=1, lives 3->2, frog_reset=1 for 1 cycle, hazard=0; game_state=0 after 3 cycles.
- Win: frog=19'h40000 in PLAY -> game_state=2, score 0->1, frog_reset 1-cycle pulse; back to PLAY after 3 cycles.
- Game over: three collisions -> game_state=3, lives=0, game_over=1, frog_reset held 1; frog=19'h40000 is ignored (score unchanged); rst=0 restores lives=3.
- Speedup (FROG_SPEEDUP_EN, TICK_DIV=16): 3 wins -> tick periods are 16, 14, 12, 10 cycles; 6 more wins -> period floors at 4.
